ps2_key_buffer: RTL and testbench
=================================

Name: ps2_key_buffer

Overview:
PS/2 keyboard receiver and event FIFO that feeds the CPU's KEY writeback path; the LDKEY instruction selects it through RegStoreCtrl = KEY. It deserialises 11-bit PS/2 frames and folds E0/F0 prefixes into single key events. Events are queued, and the CPU polls and consumes them one word per LDKEY.

Parameters:
FIFO_DEPTH, 4, number of queued key events; must be a power of 2, minimum 2.
TIMEOUT, 100000, Clk cycles without a PS2Clk falling edge before a partial frame is abandoned (2 ms at 50 MHz).
CNT_W, 17, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
PS2Clk  input  1  raw keyboard clock, asynchronous to Clk.
PS2Data  input  1  raw keyboard data, asynchronous to Clk.
KeyPop  input  1  one-cycle strobe from control: consume the head event.
KeyData  output  16  head event word, or 16'h0000 when the FIFO is empty.
KeyAvail  output  1  FIFO is not empty.
KeyCount  output  log2(FIFO_DEPTH)+1  number of queued events.
FrameErr  output  1  one-cycle pulse on a parity, start or stop error, or on a timeout.

Behaviour:
- Reset low, asynchronously and regardless of state:
  - FSM returns to IDLE; FIFO is emptied; prefix flags and the overflow flag are cleared.
  - Outputs: KeyData = 0, KeyAvail = 0, KeyCount = 0, FrameErr = 0.
  - Any frame in progress is lost.
- Input sync: PS2Clk and PS2Data each pass through a 2-FF synchroniser. A falling edge is detected when the synchronised clock was 1 on the previous cycle and is 0 now. Data is sampled on that cycle.
- Frame format: start bit 0, data bits D0..D7 (LSB first), odd parity, stop bit 1.
- FSM states and transitions:
  - IDLE: on a falling edge with data = 0, go to SHIFT with bitcnt = 0 and the timeout counter cleared. On a falling edge with data = 1, stay in IDLE and pulse FrameErr.
  - SHIFT: on each falling edge, shift data into an 9-bit register (8 data bits plus parity), increment bitcnt and clear the timeout counter. When bitcnt reaches 9, go to STOP.
  - STOP: on a falling edge, sample the stop bit and go to CHECK.
  - CHECK: lasts one cycle, then returns to IDLE. The frame is valid only if stop = 1 and XOR of the 8 data bits and parity is 1. An invalid frame pulses FrameErr, clears both prefix flags and pushes nothing.
  - Timeout: in SHIFT or STOP, if the counter reaches TIMEOUT, go to IDLE, pulse FrameErr and clear the prefix flags.
- Valid-byte handling in CHECK:
  - 8'hE0 sets ext and pushes nothing.
  - 8'hF0 sets rel and pushes nothing.
  - Any other byte pushes a word and clears ext and rel.
- Event word layout:
  - [15] = 1 (valid)
  - [14] = overflow flag
  - [13:10] = 0
  - [9] = ext
  - [8] = rel
  - [7:0] = scan code
- Overflow rules:
  - A push while the FIFO is full and KeyPop is 0 drops the new event and sets the sticky overflow flag.
  - The flag is reported in bit 14 of every word read while it is set.
  - The flag clears on the first KeyPop after it was set.
- Push and pop in the same cycle:
  - FIFO full: both happen, so the head advances and the new word enters. KeyCount is unchanged and no overflow occurs.
  - FIFO empty: the pop is ignored and the push occurs.
- KeyPop on an empty FIFO has no effect.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. KeyCount is a separate counter and never exceeds FIFO_DEPTH.
- KeyData is combinational from the head entry. A popped word disappears in the cycle after the KeyPop edge. LDKEY latches KeyData before issuing KeyPop.
- Latency: an event word is visible on KeyData 2 Clk cycles after the falling edge that carries the stop bit: 1 cycle in CHECK, then the FIFO write.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state encodings IDLE, SHIFT, STOP, CHECK
  - constants PS2_EXT = 8'hE0 and PS2_BRK = 8'hF0
  - event word bit positions KEY_VALID = 15, KEY_OVF = 14, KEY_EXT = 9, KEY_REL = 8
- One sub-module, key_fifo: a synchronous FIFO with push/pop, full/empty and count, parameterised by depth and width.
- The frame FSM, synchroniser and prefix logic stay in ps2_key_buffer.

Test Plan:
- Make frame with data 8'h1C and parity 0 -> KeyAvail = 1; KeyData = 16'h801C two cycles after the stop edge; after KeyPop, KeyData = 0 and KeyCount = 0.
- Send sequence E0, F0, 75 -> exactly one word, 16'h8375; KeyCount = 1.
- Make frame 8'h1C with the parity bit flipped -> FrameErr pulses once; nothing is pushed; a following valid 8'h1B is queued as 16'h801B with no stale prefix bits.
- Send 5 make codes 8'h15..8'h19 with FIFO_DEPTH = 4 and no pops -> KeyCount = 4; 8'h19 is dropped; first read is 16'hC015; after that pop, the next read is 16'h8016.
- Stop PS2Clk after 4 data bits for more than TIMEOUT cycles -> FrameErr pulses and the FSM is back in IDLE; the next full frame 8'h29 is received as 16'h8029.
- Pulse Reset low in mid-frame with 2 events queued -> KeyCount = 0 and KeyData = 0 immediately; the next complete frame is received normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key buffer: frame FSM states, prefix bytes
// and the layout of the event word handed to the CPU.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STOP  = 2'd2,
      CHECK = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   localparam int KEY_VALID = 15;
   localparam int KEY_OVF   = 14;
   localparam int KEY_EXT   = 9;
   localparam int KEY_REL   = 8;

   // Overflow bit is left clear here; it is merged in when the head is read.
   function automatic logic [15:0] make_event(input logic ext, input logic rel,
                                              input logic [7:0] code);
      logic [15:0] w;
      w            = '0;
      w[KEY_VALID] = 1'b1;
      w[KEY_EXT]   = ext;
      w[KEY_REL]   = rel;
      w[7:0]       = code;
      return w;
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous FIFO with occupancy counter. A push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle; a pop on empty is ignored.
module key_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/ps2_key_buffer.sv
// PS/2 keyboard receiver: deserialises frames, folds E0/F0 prefixes into one
// event word and queues events for the CPU to poll via LDKEY.
module ps2_key_buffer
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 100000,
   parameter int CNT_W      = 17
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          PS2Clk,
   input  logic                          PS2Data,
   input  logic                          KeyPop,
   output logic [15:0]                   KeyData,
   output logic                          KeyAvail,
   output logic [$clog2(FIFO_DEPTH):0]   KeyCount,
   output logic                          FrameErr
);

   logic             clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
   ps2_state_e       state_q, state_d;
   logic [3:0]       bitcnt_q, bitcnt_d;
   logic [8:0]       shift_q, shift_d;
   logic             stop_q, stop_d;
   logic [CNT_W-1:0] tmo_q, tmo_d;
   logic             ext_q, ext_d, rel_q, rel_d, ovf_q, ovf_d;
   logic             err_q, err_d;
   logic             fall, din, push, fifo_full, fifo_empty, timed_out;
   logic [15:0]      head;

   assign fall      = clk_prev_q & ~clk_s2_q;
   assign din       = dat_s2_q;
   assign timed_out = (tmo_q == CNT_W'(TIMEOUT));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         state_q    <= IDLE;
         bitcnt_q   <= '0;
         tmo_q      <= '0;
         ext_q      <= 1'b0;
         rel_q      <= 1'b0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         clk_s1_q   <= PS2Clk;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= PS2Data;
         dat_s2_q   <= dat_s1_q;
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         tmo_q      <= tmo_d;
         ext_q      <= ext_d;
         rel_q      <= rel_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge Clk) begin
      shift_q <= shift_d;
      stop_q  <= stop_d;
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      stop_d   = stop_q;
      tmo_d    = tmo_q;
      ext_d    = ext_q;
      rel_d    = rel_q;
      err_d    = 1'b0;
      push     = 1'b0;
      case (state_q)
         IDLE: begin
            if (fall) begin
               if (!din) begin
                  state_d  = SHIFT;
                  bitcnt_d = '0;
                  tmo_d    = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         SHIFT, STOP: begin
            if (fall) begin
               tmo_d = '0;
               if (state_q == STOP) begin
                  stop_d  = din;
                  state_d = CHECK;
               end else begin
                  // LSB first: after nine shifts [7:0] is the byte, [8] parity.
                  shift_d  = {din, shift_q[8:1]};
                  bitcnt_d = bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'd8) state_d = STOP;
               end
            end else if (timed_out) begin
               state_d = IDLE;
               err_d   = 1'b1;
               ext_d   = 1'b0;
               rel_d   = 1'b0;
            end else begin
               tmo_d = tmo_q + CNT_W'(1);
            end
         end
         CHECK: begin
            state_d = IDLE;
            if (stop_q && (^shift_q)) begin
               if (shift_q[7:0] == PS2_EXT) begin
                  ext_d = 1'b1;
               end else if (shift_q[7:0] == PS2_BRK) begin
                  rel_d = 1'b1;
               end else begin
                  push  = 1'b1;
                  ext_d = 1'b0;
                  rel_d = 1'b0;
               end
            end else begin
               err_d = 1'b1;
               ext_d = 1'b0;
               rel_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Overflow is sticky until the CPU pops; it is reported on every read meanwhile.
   always_comb begin
      ovf_d = ovf_q;
      if (push && fifo_full && !KeyPop) ovf_d = 1'b1;
      else if (KeyPop)                  ovf_d = 1'b0;
   end

   key_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk_i   (Clk),
      .rst_ni  (Reset),
      .push_i  (push),
      .pop_i   (KeyPop),
      .wdata_i (make_event(ext_q, rel_q, shift_q[7:0])),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (KeyCount)
   );

   always_comb begin
      KeyData = '0;
      if (!fifo_empty) begin
         KeyData          = head;
         KeyData[KEY_OVF] = ovf_q;
      end
   end

   assign KeyAvail = ~fifo_empty;
   assign FrameErr = err_q;

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Directed bench for ps2_key_buffer: a table of frames with expected queue
// state, plus hand-written timeout, overflow drain and reset sequences.
module tb_ps2_key_buffer;

   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT    = 200;
   localparam int CNT_W      = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ps2clk, ps2dat, key_pop;
   logic [15:0] key_data;
   logic        key_avail, frame_err;
   logic [2:0]  key_count;

   int passed = 0;
   int total  = 0;
   int err_cnt = 0;

   ps2_key_buffer #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .TIMEOUT    (TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .Clk      (clk),
      .Reset    (rst_n),
      .PS2Clk   (ps2clk),
      .PS2Data  (ps2dat),
      .KeyPop   (key_pop),
      .KeyData  (key_data),
      .KeyAvail (key_avail),
      .KeyCount (key_count),
      .FrameErr (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (frame_err) err_cnt <= err_cnt + 1;

   typedef struct {
      logic [7:0]  code;
      bit          flip;
      int          mode;
      bit          pop;
      int          exp_err;
      int          exp_cnt;
      logic [15:0] exp_data;
      int          exp_cnt2;
      logic [15:0] exp_data2;
   } vec_t;

   vec_t tbl[$];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   // mode 1: check the two-cycle write latency after the stop edge.
   // mode 2: strobe KeyPop in the CHECK cycle so push and pop coincide.
   task automatic ps2_bit(input logic d, input int mode);
      ps2dat = d;
      tick(5);
      ps2clk = 1'b0;
      if (mode == 1) begin
         tick(3);
         chk("latency_not_yet", 32'(key_avail), 32'd0);
         tick(1);
         chk("latency_visible", 32'(key_avail), 32'd1);
         tick(6);
      end else if (mode == 2) begin
         tick(3);
         key_pop = 1'b1;
         tick(1);
         key_pop = 1'b0;
         tick(6);
      end else begin
         tick(10);
      end
      ps2clk = 1'b1;
      tick(5);
   endtask

   task automatic send_frame(input logic [7:0] code, input bit flip, input int mode);
      logic [10:0] bits;
      logic        par;
      par  = ~(^code) ^ flip;
      bits = {1'b1, par, code, 1'b0};
      for (int i = 0; i < 11; i++) ps2_bit(bits[i], (i == 10) ? mode : 0);
      tick(4);
   endtask

   task automatic pop_once();
      key_pop = 1'b1;
      tick(1);
      key_pop = 1'b0;
   endtask

   initial begin
      int e0;
      logic [15:0] drain [4];

      rst_n   = 1'b0;
      ps2clk  = 1'b1;
      ps2dat  = 1'b1;
      key_pop = 1'b0;
      tick(3);
      chk("reset_data",  32'(key_data),  32'h0);
      chk("reset_avail", 32'(key_avail), 32'h0);
      chk("reset_count", 32'(key_count), 32'h0);
      chk("reset_err",   32'(frame_err), 32'h0);
      rst_n = 1'b1;
      tick(3);

      //              code  flip mode pop err cnt data      cnt2 data2
      tbl.push_back('{8'h1C, 0, 1, 1, 0, 1, 16'h801C, 0, 16'h0000});
      tbl.push_back('{8'hE0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000});
      tbl.push_back('{8'hF0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000});
      tbl.push_back('{8'h75, 0, 0, 1, 0, 1, 16'h8375, 0, 16'h0000});
      tbl.push_back('{8'h1C, 1, 0, 0, 1, 0, 16'h0000, 0, 16'h0000});
      tbl.push_back('{8'h1B, 0, 0, 1, 0, 1, 16'h801B, 0, 16'h0000});
      tbl.push_back('{8'hE0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000});
      tbl.push_back('{8'h12, 1, 0, 0, 1, 0, 16'h0000, 0, 16'h0000});
      tbl.push_back('{8'h5A, 0, 0, 1, 0, 1, 16'h805A, 0, 16'h0000});
      tbl.push_back('{8'hE0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000});
      tbl.push_back('{8'h6B, 0, 0, 1, 0, 1, 16'h826B, 0, 16'h0000});
      tbl.push_back('{8'hF0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000});
      tbl.push_back('{8'h29, 0, 0, 1, 0, 1, 16'h8129, 0, 16'h0000});
      tbl.push_back('{8'h15, 0, 0, 0, 0, 1, 16'h8015, 0, 16'h0000});
      tbl.push_back('{8'h16, 0, 0, 0, 0, 2, 16'h8015, 0, 16'h0000});
      tbl.push_back('{8'h17, 0, 0, 0, 0, 3, 16'h8015, 0, 16'h0000});
      tbl.push_back('{8'h18, 0, 0, 0, 0, 4, 16'h8015, 0, 16'h0000});
      tbl.push_back('{8'h19, 0, 0, 1, 0, 4, 16'hC015, 3, 16'h8016});
      tbl.push_back('{8'h21, 0, 0, 0, 0, 4, 16'h8016, 0, 16'h0000});
      tbl.push_back('{8'h22, 0, 2, 0, 0, 4, 16'h8017, 0, 16'h0000});

      foreach (tbl[i]) begin
         e0 = err_cnt;
         send_frame(tbl[i].code, tbl[i].flip, tbl[i].mode);
         chk($sformatf("v%0d_err", i),   32'(err_cnt - e0), 32'(tbl[i].exp_err));
         chk($sformatf("v%0d_count", i), 32'(key_count),    32'(tbl[i].exp_cnt));
         chk($sformatf("v%0d_data", i),  32'(key_data),     32'(tbl[i].exp_data));
         chk($sformatf("v%0d_avail", i), 32'(key_avail),    32'(tbl[i].exp_cnt != 0));
         if (tbl[i].pop) begin
            pop_once();
            chk($sformatf("v%0d_count_pop", i), 32'(key_count), 32'(tbl[i].exp_cnt2));
            chk($sformatf("v%0d_data_pop", i),  32'(key_data),  32'(tbl[i].exp_data2));
         end
      end

      // Drain the full FIFO left by the table.
      drain = '{16'h8017, 16'h8018, 16'h8021, 16'h8022};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain%0d", i), 32'(key_data), 32'(drain[i]));
         pop_once();
      end
      chk("drain_count", 32'(key_count), 32'd0);
      chk("drain_data",  32'(key_data),  32'h0);

      pop_once();
      chk("pop_empty_count", 32'(key_count), 32'd0);
      chk("pop_empty_avail", 32'(key_avail), 32'd0);

      // Push and pop together on an empty FIFO: only the push happens.
      send_frame(8'h33, 1'b0, 2);
      chk("empty_pushpop_count", 32'(key_count), 32'd1);
      chk("empty_pushpop_data",  32'(key_data),  32'h8033);
      pop_once();

      // High data bit seen on a falling edge in IDLE is a start error.
      e0 = err_cnt;
      ps2_bit(1'b1, 0);
      tick(4);
      chk("start_err", 32'(err_cnt - e0), 32'd1);
      chk("start_err_count", 32'(key_count), 32'd0);

      // Abandon a frame after four data bits.
      e0 = err_cnt;
      ps2_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0);
      tick(TIMEOUT + 60);
      chk("timeout_err", 32'(err_cnt - e0), 32'd1);
      send_frame(8'h29, 1'b0, 0);
      chk("after_timeout_count", 32'(key_count), 32'd1);
      chk("after_timeout_data",  32'(key_data),  32'h8029);
      pop_once();

      // Reset in the middle of a frame with two events queued.
      send_frame(8'h15, 1'b0, 0);
      send_frame(8'h16, 1'b0, 0);
      chk("pre_reset_count", 32'(key_count), 32'd2);
      ps2_bit(1'b0, 0);
      ps2_bit(1'b1, 0);
      ps2_bit(1'b0, 0);
      rst_n = 1'b0;
      #1;
      chk("midreset_count", 32'(key_count), 32'd0);
      chk("midreset_data",  32'(key_data),  32'h0);
      chk("midreset_avail", 32'(key_avail), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      send_frame(8'h3A, 1'b0, 0);
      chk("post_reset_count", 32'(key_count), 32'd1);
      chk("post_reset_data",  32'(key_data),  32'h803A);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
